// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the Mini-SRC hardwired control unit: opcodes, FSM states,
// the packed strobe vector and the per-opcode final execute step.
package cpu_ctrl_pkg;

  localparam int unsigned MEM_WAIT_MAX = 7;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, cout;
    logic pcout, zhighout, zlowout, mdrout, hiout, loout, inportout;
    logic pcin, irin, yin, zin, marin, mdrin, hiin, loin, conin, outportin;
    logic incpc, read, write;
    logic alu_and, alu_or, alu_add, alu_sub, alu_mul, alu_div;
    logic alu_shr, alu_shl, alu_ror, alu_rol, alu_neg, alu_not;
    logic run, clear;
  } ctrl_t;

  // Stop is sampled and the instruction retires on this step.
  function automatic state_t last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                              return ST_T7;
      OP_MUL, OP_DIV, OP_BR:                     return ST_T6;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:          return ST_T5;
      OP_NEG, OP_NOT, OP_JAL:                    return ST_T4;
      default:                                   return ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-strobe bundle between the control unit (master) and Datapath_P3 (slave).
interface control_unit_if;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortin;
  logic IncPC, Read, Write;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT;
  logic Run, Clear;

  modport master (
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout,
    output PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortin,
    output IncPC, Read, Write,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT,
    output Run, Clear
  );

  modport slave (
    input Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout,
    input PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortin,
    input IncPC, Read, Write,
    input AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT,
    input Run, Clear
  );
endinterface

// File: rtl/control_decode.sv
// Moore strobe decode: maps {state, latched opcode, CON_FF} to the datapath
// control vector. Purely combinational.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       first,
  output ctrl_t      ctrl
);

  ctrl_t c;
  logic  alu_en;

  always_comb begin
    c      = '0;
    alu_en = 1'b0;
    c.run   = (state != ST_RST) && (state != ST_HALT);
    c.clear = (state == ST_RST);

    case (state)
      ST_T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; end
      ST_T1: begin c.zlowout = 1'b1; c.pcin = first; c.read = 1'b1; c.mdrin = 1'b1; end
      ST_T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      ST_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI:  begin c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
          OP_LDI, OP_LD, OP_ST:      begin c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1; end
          OP_MUL, OP_DIV:            begin c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
          OP_NEG, OP_NOT:            begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; alu_en = 1'b1; end
          OP_BR:                     begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
          OP_JR:                     begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
          OP_JAL:                    begin c.pcout = 1'b1; c.grb = 1'b1; c.rin = 1'b1; end
          OP_IN:                     begin c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_OUT:                    begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; end
          OP_MFHI:                   begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_MFLO:                   begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHL:
                                     begin c.grc = 1'b1; c.rout = 1'b1; c.zin = 1'b1; alu_en = 1'b1; end
          OP_ADDI, OP_ANDI, OP_ORI:  begin c.cout = 1'b1; c.zin = 1'b1; alu_en = 1'b1; end
          OP_LDI, OP_LD, OP_ST:      begin c.cout = 1'b1; c.alu_add = 1'b1; c.zin = 1'b1; end
          OP_MUL, OP_DIV:            begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; alu_en = 1'b1; end
          OP_NEG, OP_NOT:            begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_BR:                     begin c.pcout = 1'b1; c.yin = 1'b1; end
          OP_JAL:                    begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                                     begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_LD, OP_ST:              begin c.zlowout = 1'b1; c.marin = 1'b1; end
          OP_MUL, OP_DIV:            begin c.zlowout = 1'b1; c.loin = 1'b1; end
          OP_BR:                     begin c.cout = 1'b1; c.alu_add = 1'b1; c.zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (opcode)
          OP_LD:                     begin c.read = 1'b1; c.mdrin = 1'b1; end
          OP_ST:                     begin c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1; end
          OP_MUL, OP_DIV:            begin c.zhighout = 1'b1; c.hiin = 1'b1; end
          OP_BR:                     begin c.zlowout = con_ff; c.pcin = con_ff; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (opcode)
          OP_LD:                     begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_ST:                     c.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase

    if (alu_en) begin
      case (opcode)
        OP_ADD, OP_ADDI: c.alu_add = 1'b1;
        OP_SUB:          c.alu_sub = 1'b1;
        OP_AND, OP_ANDI: c.alu_and = 1'b1;
        OP_OR, OP_ORI:   c.alu_or  = 1'b1;
        OP_ROR:          c.alu_ror = 1'b1;
        OP_ROL:          c.alu_rol = 1'b1;
        OP_SHR:          c.alu_shr = 1'b1;
        OP_SHL:          c.alu_shl = 1'b1;
        OP_MUL:          c.alu_mul = 1'b1;
        OP_DIV:          c.alu_div = 1'b1;
        OP_NEG:          c.alu_neg = 1'b1;
        OP_NOT:          c.alu_not = 1'b1;
        default: ;
      endcase
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini-SRC control FSM: state register, memory wait counter and
// opcode latch; strobe decoding lives in control_decode.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  input  logic        Interrupts,
  control_unit_if.master ctl
);

  localparam int unsigned WAIT_CLAMP = (MEM_WAIT > MEM_WAIT_MAX) ? MEM_WAIT_MAX : MEM_WAIT;
  localparam logic [2:0]  WAIT_LAST  = 3'(WAIT_CLAMP);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [4:0] opcode_q, opcode_d;
  logic       stretch, hold;
  ctrl_t      ctrl;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_RST;
      wait_q   <= '0;
      opcode_q <= OP_NOP;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      opcode_q <= opcode_d;
    end
  end

  // Memory steps dwell MEM_WAIT extra cycles before advancing.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    opcode_d = opcode_q;
    stretch  = (state_q == ST_T1) ||
               ((state_q == ST_T6) && (opcode_q == OP_LD)) ||
               ((state_q == ST_T7) && (opcode_q == OP_ST));
    hold     = stretch && (wait_q != WAIT_LAST);

    if (hold) begin
      wait_d = wait_q + 3'd1;
    end else begin
      wait_d = '0;
      case (state_q)
        ST_RST:  state_d = ST_T0;
        ST_T0:   state_d = ST_T1;
        ST_T1:   state_d = ST_T2;
        ST_T2: begin
          state_d  = ST_T3;
          opcode_d = IR[31:27];
        end
        ST_HALT: state_d = ST_HALT;
        default: begin
          if (state_q == last_step(opcode_q))
            state_d = ((opcode_q == OP_HALT) || Stop) ? ST_HALT : ST_T0;
          else
            state_d = state_t'(state_q + 4'd1);
        end
      endcase
    end
  end

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode_q),
    .con_ff (CON_FF),
    .first  (wait_q == '0),
    .ctrl   (ctrl)
  );

  assign {ctl.Gra, ctl.Grb, ctl.Grc, ctl.Rin, ctl.Rout, ctl.BAout, ctl.Cout,
          ctl.PCout, ctl.Zhighout, ctl.Zlowout, ctl.MDRout, ctl.HIout, ctl.LOout, ctl.InPortout,
          ctl.PCin, ctl.IRin, ctl.Yin, ctl.Zin, ctl.MARin, ctl.MDRin, ctl.HIin, ctl.LOin,
          ctl.CONin, ctl.OutPortin, ctl.IncPC, ctl.Read, ctl.Write,
          ctl.AND, ctl.OR, ctl.ADD, ctl.SUB, ctl.MUL, ctl.DIV,
          ctl.SHR, ctl.SHL, ctl.ROR, ctl.ROL, ctl.NEG, ctl.NOT,
          ctl.Run, ctl.Clear} = ctrl;

  logic unused_inputs;
  assign unused_inputs = ^{IR[26:0], Interrupts};

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instruction sequences push
// per-cycle expected strobe vectors; a negedge monitor pops and compares.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic        Clock;
  logic        rst0, rst2;
  logic [31:0] ir0, ir2;
  logic        con0, stop0, stop2;

  control_unit_if if0 ();
  control_unit_if if2 ();

  control_unit #(.MEM_WAIT(0)) dut0 (
    .Clock(Clock), .Reset(rst0), .IR(ir0), .CON_FF(con0), .Stop(stop0),
    .Interrupts(1'b1), .ctl(if0)
  );

  control_unit #(.MEM_WAIT(2)) dut2 (
    .Clock(Clock), .Reset(rst2), .IR(ir2), .CON_FF(1'b0), .Stop(stop2),
    .Interrupts(1'b0), .ctl(if2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  ctrl_t act0, act2;
  assign act0 = {if0.Gra, if0.Grb, if0.Grc, if0.Rin, if0.Rout, if0.BAout, if0.Cout,
                 if0.PCout, if0.Zhighout, if0.Zlowout, if0.MDRout, if0.HIout, if0.LOout, if0.InPortout,
                 if0.PCin, if0.IRin, if0.Yin, if0.Zin, if0.MARin, if0.MDRin, if0.HIin, if0.LOin,
                 if0.CONin, if0.OutPortin, if0.IncPC, if0.Read, if0.Write,
                 if0.AND, if0.OR, if0.ADD, if0.SUB, if0.MUL, if0.DIV,
                 if0.SHR, if0.SHL, if0.ROR, if0.ROL, if0.NEG, if0.NOT, if0.Run, if0.Clear};
  assign act2 = {if2.Gra, if2.Grb, if2.Grc, if2.Rin, if2.Rout, if2.BAout, if2.Cout,
                 if2.PCout, if2.Zhighout, if2.Zlowout, if2.MDRout, if2.HIout, if2.LOout, if2.InPortout,
                 if2.PCin, if2.IRin, if2.Yin, if2.Zin, if2.MARin, if2.MDRin, if2.HIin, if2.LOin,
                 if2.CONin, if2.OutPortin, if2.IncPC, if2.Read, if2.Write,
                 if2.AND, if2.OR, if2.ADD, if2.SUB, if2.MUL, if2.DIV,
                 if2.SHR, if2.SHL, if2.ROR, if2.ROL, if2.NEG, if2.NOT, if2.Run, if2.Clear};

  ctrl_t q0[$], q2[$];
  string n0[$], n2[$];
  int    tests  = 0;
  int    failed = 0;

  always @(negedge Clock) begin
    ctrl_t e;
    string n;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n = n0.pop_front();
      tests++;
      if (act0 !== e) begin
        failed++;
        $display("FAIL dut0 %s: got %h expected %h", n, act0, e);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      n = n2.pop_front();
      tests++;
      if (act2 !== e) begin
        failed++;
        $display("FAIL dut2 %s: got %h expected %h", n, act2, e);
      end
    end
  end

  task automatic push(input int d, input ctrl_t e, input string n, input int unsigned reps = 1);
    for (int unsigned i = 0; i < reps; i++) begin
      if (d == 0) begin q0.push_back(e); n0.push_back(n); end
      else        begin q2.push_back(e); n2.push_back(n); end
    end
  endtask

  function automatic ctrl_t rv();
    ctrl_t e;
    e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t clr();
    ctrl_t e;
    e = '0;
    e.clear = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 4'd1, 4'd2, 4'd3, 15'd0};
  endfunction

  task automatic push_fetch(input int d, input int unsigned mw);
    ctrl_t e;
    e = rv(); e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zin = 1'b1; push(d, e, "T0");
    e = rv(); e.zlowout = 1'b1; e.pcin = 1'b1; e.read = 1'b1; e.mdrin = 1'b1; push(d, e, "T1");
    e.pcin = 1'b0; push(d, e, "T1_wait", mw);
    e = rv(); e.mdrout = 1'b1; e.irin = 1'b1; push(d, e, "T2");
  endtask

  // ld/st share T3-T5: base+offset into MAR.
  task automatic push_addr(input int d);
    ctrl_t e;
    e = rv(); e.grb = 1'b1; e.baout = 1'b1; e.yin = 1'b1; push(d, e, "mem_T3");
    e = rv(); e.cout = 1'b1; e.alu_add = 1'b1; e.zin = 1'b1; push(d, e, "mem_T4");
    e = rv(); e.zlowout = 1'b1; e.marin = 1'b1; push(d, e, "mem_T5");
  endtask

  task automatic push_br(input logic con);
    ctrl_t e;
    push_fetch(0, 0);
    e = rv(); e.gra = 1'b1; e.rout = 1'b1; e.conin = 1'b1; push(0, e, "br_T3");
    e = rv(); e.pcout = 1'b1; e.yin = 1'b1; push(0, e, "br_T4");
    e = rv(); e.cout = 1'b1; e.alu_add = 1'b1; e.zin = 1'b1; push(0, e, "br_T5");
    e = rv(); e.zlowout = con; e.pcin = con; push(0, e, con ? "br_T6_con1" : "br_T6_con0");
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_drain();
    for (int unsigned i = 0; i < 200; i++) begin
      tick();
      if (q0.size() == 0 && q2.size() == 0) return;
    end
    $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q2.size());
    $fatal(1, "scoreboard did not drain");
  endtask

  initial begin
    ctrl_t e;
    rst0 = 1'b1; rst2 = 1'b1; con0 = 1'b0; stop0 = 1'b0; stop2 = 1'b0;
    ir0 = mk_ir(OP_ADD); ir2 = mk_ir(OP_LD);
    #1;
    rst0 = 1'b0; rst2 = 1'b0;

    // Reset held 3 cycles, one Clear cycle after release, then add R1,R2,R3.
    tick();
    push(0, clr(), "reset_low", 3);
    wait_drain();
    rst0 = 1'b1;
    push(0, clr(), "rst_release");
    push_fetch(0, 0);
    e = rv(); e.grb = 1'b1; e.rout = 1'b1; e.yin = 1'b1; push(0, e, "add_T3");
    e = rv(); e.grc = 1'b1; e.rout = 1'b1; e.alu_add = 1'b1; e.zin = 1'b1; push(0, e, "add_T4");
    e = rv(); e.zlowout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; push(0, e, "add_T5");
    wait_drain();

    ir0 = mk_ir(OP_BR); con0 = 1'b0;
    push_br(1'b0);
    wait_drain();
    con0 = 1'b1;
    push_br(1'b1);
    wait_drain();

    // mul with Stop raised in T4: finishes HIin in T6 then halts.
    ir0 = mk_ir(OP_MUL); con0 = 1'b0;
    push_fetch(0, 0);
    e = rv(); e.gra = 1'b1; e.rout = 1'b1; e.yin = 1'b1; push(0, e, "mul_T3");
    e = rv(); e.grb = 1'b1; e.rout = 1'b1; e.alu_mul = 1'b1; e.zin = 1'b1; push(0, e, "mul_T4");
    e = rv(); e.zlowout = 1'b1; e.loin = 1'b1; push(0, e, "mul_T5");
    e = rv(); e.zhighout = 1'b1; e.hiin = 1'b1; push(0, e, "mul_T6");
    push(0, '0, "halt_after_stop", 3);
    repeat (4) tick();
    stop0 = 1'b1;
    wait_drain();

    // Leave HALT by reset, then reset again in the middle of st T6.
    rst0 = 1'b0; stop0 = 1'b0; ir0 = mk_ir(OP_ST);
    push(0, clr(), "halt_reset");
    wait_drain();
    rst0 = 1'b1;
    push(0, clr(), "rst_release2");
    push_fetch(0, 0);
    push_addr(0);
    wait_drain();
    rst0 = 1'b0;
    push(0, clr(), "st_T6_reset", 2);
    wait_drain();
    rst0 = 1'b1; ir0 = mk_ir(OP_HALT);
    push(0, clr(), "rst_release3");
    push_fetch(0, 0);
    push(0, rv(), "halt_T3");
    push(0, '0, "halt_opcode", 2);
    wait_drain();

    // MEM_WAIT = 2: ld takes 12 cycles; st with Stop held high is not aborted.
    push(2, clr(), "reset_low2");
    wait_drain();
    rst2 = 1'b1;
    push(2, clr(), "rst_release_mw2");
    push_fetch(2, 2);
    push_addr(2);
    e = rv(); e.read = 1'b1; e.mdrin = 1'b1; push(2, e, "ld_T6", 3);
    e = rv(); e.mdrout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; push(2, e, "ld_T7");
    wait_drain();
    ir2 = mk_ir(OP_ST); stop2 = 1'b1;
    push_fetch(2, 2);
    push_addr(2);
    e = rv(); e.gra = 1'b1; e.rout = 1'b1; e.mdrin = 1'b1; push(2, e, "st_T6");
    e = rv(); e.write = 1'b1; push(2, e, "st_T7", 3);
    push(2, '0, "halt_after_st", 2);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Mini-SRC control FSM: the driving end of the control-signal interface that Datapath_P3 consumes.
- Sequences fetch (T0–T2) and per-opcode execute steps from IR and CON_FF.
- Drives every datapath strobe: register-select, bus-out, register-in, ALU-op and memory.
- Owns Run/Clear and halt handling; instantiated beside Datapath_P3 in the system top.

Parameters:
- MEM_WAIT, 0, extra cycles Read is held in every memory-read step (0..7); same stretch applies to Write in st T7.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register; opcode = IR[31:27].
- CON_FF  in  1  branch-condition flop from datapath.
- Stop  in  1  halt request, sampled at instruction boundary.
- Interrupts  in  1  reserved; ignored, must not affect state.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-file select and control.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout  out  1 each  bus drivers.
- PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OutPortin  out  1 each  register loads.
- IncPC, Read, Write  out  1 each  PC-increment and memory strobes.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT  out  1 each  one-hot ALU op.
- Run  out  1  high while executing.
- Clear  out  1  datapath clear.

Behaviour:
- Reset low (async): state = RST.
  - All outputs 0 except Clear = 1; Run = 0.
- RST: Clear = 1 for the first cycle after Reset rises, then → T0; Run = 1 from T0 on.
- Outputs are Moore, decoded from state plus latched opcode. At most one ALU op is high per cycle; at most one bus driver is high per cycle.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin; held MEM_WAIT+1 cycles via wait counter, PCin only in the first of them.
  - T2: MDRout, IRin.
- Opcode is latched from IR at T3 entry.
- ALU reg (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shl 01011):
  - T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
- Immediate (addi 01100 ADD, andi 01101 AND, ori 01110 OR):
  - T3 Grb Rout Yin; T4 Cout op Zin; T5 Zlowout Gra Rin.
- ldi 00001: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
- ld 00000:
  - T3–T4 as ldi; T5 Zlowout MARin.
  - T6 Read MDRin, MEM_WAIT-stretched.
  - T7 MDRout Gra Rin.
- st 00010:
  - T3–T5 as ld.
  - T6 Gra Rout MDRin, Read = 0.
  - T7 Write, MEM_WAIT-stretched.
- mul 01111 / div 10000:
  - T3 Gra Rout Yin; T4 Grb Rout MUL|DIV Zin.
  - T5 Zlowout LOin; T6 Zhighout HIin.
- neg 10001 / not 10010: T3 Grb Rout NEG|NOT Zin; T4 Zlowout Gra Rin.
- br 10011:
  - T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin.
  - T6: Zlowout PCin only if CON_FF = 1 (sampled in T6), else no strobes.
- jr 10100: T3 Gra Rout PCin.
- jal 10101: T3 PCout Grb Rin (link); T4 Gra Rout PCin.
- in 10110: T3 InPortout Gra Rin.
- out 10111: T3 Gra Rout OutPortin.
- mfhi 11000: T3 HIout Gra Rin.
- mflo 11001: T3 LOout Gra Rin.
- nop 11010, shra 01010 and undefined opcodes (11100–11111): no execute step; T3 → T0.
- halt 11011: → HALT; Run = 0, all strobes 0. Exit only by Reset.
- Stop: sampled on the last execute step of each instruction. If high → HALT instead of T0. Stop never aborts an instruction mid-sequence.
- Reset mid-instruction: immediate return to RST; no partial strobes after assertion.
- Instruction cycle count = 3 + (MEM_WAIT in T1) + execute steps + waits.

Decomposition:
- Package cpu_ctrl_pkg:
  - 5-bit opcode localparams.
  - State encoding (RST, T0–T7, HALT).
  - MEM_WAIT bound.
- Sub-module control_decode: combinational map from {state, opcode, CON_FF} to the output strobe vector.
- control_unit holds the state register, wait counter and opcode latch.

Test Plan:
- Reset low 3 cycles then high → Clear = 1 for one cycle after release, Run = 1 from T0; T0 asserts PCout, MARin, IncPC, Zin together.
- IR = add R1,R2,R3, MEM_WAIT = 0 → strobes exactly per T0–T5 table; total 6 cycles; ADD high only in T4.
- ld with MEM_WAIT = 2 → Read+MDRin high 3 cycles in T1 and 3 cycles in T6; instruction takes 12 cycles.
- br, CON_FF = 0 then 1 → PCin absent in T6 for 0, present for 1; all other strobes identical.
- Stop raised during T4 of mul → mul completes HIin in T6, then HALT, Run = 0, no further IRin; halt opcode gives the same HALT.
- Reset asserted during st T6 → Write never asserts, outputs zero except Clear, restart at T0.
